// File: rtl/ss_game_pkg.sv
// Shared constants for the SubtractSquare turn controller: FSM encodings,
// player identifiers and the forced-move input value.
package ss_game_pkg;

  typedef logic [3:0] state_t;

  localparam state_t IDLE      = 4'd0;
  localparam state_t RST_MV    = 4'd1;
  localparam state_t ARM       = 4'd2;
  localparam state_t INIT_WAIT = 4'd3;
  localparam state_t TURN_WAIT = 4'd4;
  localparam state_t ISSUE     = 4'd5;
  localparam state_t SETTLE    = 4'd6;
  localparam state_t CHECK     = 4'd7;
  localparam state_t ROUND_END = 4'd8;
  localparam state_t MATCH_END = 4'd9;

  localparam logic PLAYER_1 = 1'b0;
  localparam logic PLAYER_2 = 1'b1;

  // single_move rejects a zero root, so loading it yields the forced move
  localparam logic [3:0] FORCED_INPUT = 4'd0;

endpackage

// File: rtl/game_turn_controller_if.sv
// Keypad, single_move and status signals of the turn controller.
// slave = controller side, master = board / environment side.
interface game_turn_controller_if;
  logic       start;
  logic       p1_load;
  logic       p2_load;
  logic [3:0] p1_input;
  logic [3:0] p2_input;
  logic [7:0] game_state;
  logic       move_reset;
  logic       move_start;
  logic       move_load;
  logic [3:0] move_input;
  logic       turn;
  logic       timeout_flag;
  logic       round_over;
  logic       round_winner;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic       match_over;

  modport slave (
    input  start, p1_load, p2_load, p1_input, p2_input, game_state,
    output move_reset, move_start, move_load, move_input, turn, timeout_flag,
           round_over, round_winner, p1_score, p2_score, match_over
  );

  modport master (
    output start, p1_load, p2_load, p1_input, p2_input, game_state,
    input  move_reset, move_start, move_load, move_input, turn, timeout_flag,
           round_over, round_winner, p1_score, p2_score, match_over
  );
endinterface

// File: rtl/turn_timer.sv
// Saturating cycle counter with a terminal-count flag. Counts while enabled,
// holds at COUNT-1 (never wraps), and returns to zero on clear.
module turn_timer #(
  parameter int          CNT_W = 28,
  parameter int unsigned COUNT = 150000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  logic [CNT_W-1:0] cnt_q;

  // count up while enabled, stop at the last value
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n)                     cnt_q <= '0;
    else if (clear)                  cnt_q <= '0;
    else if (enable && cnt_q != LAST) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign tc = enable && (cnt_q == LAST);
endmodule

// File: rtl/game_turn_controller.sv
// Runs single_move through two-player SubtractSquare matches: routes the
// active player's key, forces a move on turn timeout, scores rounds and
// re-arms single_move until one player reaches WIN_SCORE.
module game_turn_controller
  import ss_game_pkg::*;
#(
  parameter int          CNT_W         = 28,
  parameter int unsigned TURN_TIMEOUT  = 150000000,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned WIN_SCORE     = 3
) (
  input logic                   clk,
  input logic                   reset_n,
  game_turn_controller_if.slave bus
);
  localparam int         SET_W = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [3:0] WIN   = 4'(WIN_SCORE);

  state_t     state_q, state_d;
  logic       start_q, p1_load_q, p2_load_q;
  logic       turn_q, turn_d;
  logic [3:0] mv_in_q, mv_in_d;
  logic       to_flag_q, to_flag_d;
  logic       rnd_over_q, rnd_over_d;
  logic       rnd_win_q, rnd_win_d;
  logic [3:0] p1_sc_q, p1_sc_d;
  logic [3:0] p2_sc_q, p2_sc_d;
  logic       match_q, match_d;

  logic       start_ev, p1_ev, p2_ev, act_ev;
  logic [3:0] act_in;
  logic       turn_tc, settle_tc, settling, score_hit;

  assign start_ev  = bus.start   & ~start_q;
  assign p1_ev     = bus.p1_load & ~p1_load_q;
  assign p2_ev     = bus.p2_load & ~p2_load_q;
  // only the active player's key counts, even on a simultaneous press
  assign act_ev    = (turn_q == PLAYER_2) ? p2_ev : p1_ev;
  assign act_in    = (turn_q == PLAYER_2) ? bus.p2_input : bus.p1_input;
  assign settling  = (state_q == INIT_WAIT) || (state_q == SETTLE);
  assign score_hit = (p1_sc_q == WIN) || (p2_sc_q == WIN);

  turn_timer #(.CNT_W(CNT_W), .COUNT(TURN_TIMEOUT)) u_turn_tmr (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_q != TURN_WAIT),
    .enable  (state_q == TURN_WAIT),
    .tc      (turn_tc)
  );

  // same counter gives the wait for single_move's output to settle
  turn_timer #(.CNT_W(SET_W), .COUNT(SETTLE_CYCLES)) u_settle_tmr (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!settling),
    .enable  (settling),
    .tc      (settle_tc)
  );

  // key edge detectors
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      start_q   <= 1'b0;
      p1_load_q <= 1'b0;
      p2_load_q <= 1'b0;
    end else begin
      start_q   <= bus.start;
      p1_load_q <= bus.p1_load;
      p2_load_q <= bus.p2_load;
    end
  end

  // match sequencing: next state, turn, latched move and scores
  always_comb begin
    state_d    = state_q;
    turn_d     = turn_q;
    mv_in_d    = mv_in_q;
    to_flag_d  = 1'b0;
    rnd_over_d = rnd_over_q;
    rnd_win_d  = rnd_win_q;
    p1_sc_d    = p1_sc_q;
    p2_sc_d    = p2_sc_q;
    match_d    = match_q;
    case (state_q)
      IDLE: if (start_ev) begin
        p1_sc_d = 4'd0;
        p2_sc_d = 4'd0;
        turn_d  = PLAYER_1;
        state_d = RST_MV;
      end
      RST_MV: state_d = ARM;
      ARM:    state_d = INIT_WAIT;
      // a zero starting pile is unplayable, so re-arm single_move
      INIT_WAIT: if (settle_tc) state_d = (bus.game_state == 8'd0) ? RST_MV : TURN_WAIT;
      TURN_WAIT: begin
        if (act_ev) begin
          mv_in_d = act_in;
          state_d = ISSUE;
        end else if (turn_tc) begin
          mv_in_d   = FORCED_INPUT;
          to_flag_d = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE:  state_d = SETTLE;
      SETTLE: if (settle_tc) state_d = CHECK;
      CHECK: begin
        if (bus.game_state == 8'd0) begin
          // the mover emptied the pile and takes the round
          if (turn_q == PLAYER_1) begin
            if (p1_sc_q < WIN) p1_sc_d = p1_sc_q + 4'd1;
          end else begin
            if (p2_sc_q < WIN) p2_sc_d = p2_sc_q + 4'd1;
          end
          rnd_win_d  = turn_q;
          rnd_over_d = 1'b1;
          state_d    = ROUND_END;
        end else begin
          turn_d  = ~turn_q;
          state_d = TURN_WAIT;
        end
      end
      ROUND_END: begin
        if (score_hit) begin
          match_d = 1'b1;
          state_d = MATCH_END;
        end else if (start_ev) begin
          rnd_over_d = 1'b0;
          turn_d     = ~rnd_win_q;
          state_d    = RST_MV;
        end
      end
      MATCH_END: if (start_ev) begin
        p1_sc_d    = 4'd0;
        p2_sc_d    = 4'd0;
        rnd_over_d = 1'b0;
        match_d    = 1'b0;
        state_d    = RST_MV;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and status registers
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q    <= IDLE;
      turn_q     <= PLAYER_1;
      mv_in_q    <= 4'd0;
      to_flag_q  <= 1'b0;
      rnd_over_q <= 1'b0;
      rnd_win_q  <= 1'b0;
      p1_sc_q    <= 4'd0;
      p2_sc_q    <= 4'd0;
      match_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      turn_q     <= turn_d;
      mv_in_q    <= mv_in_d;
      to_flag_q  <= to_flag_d;
      rnd_over_q <= rnd_over_d;
      rnd_win_q  <= rnd_win_d;
      p1_sc_q    <= p1_sc_d;
      p2_sc_q    <= p2_sc_d;
      match_q    <= match_d;
    end
  end

  assign bus.move_reset   = (state_q == IDLE) || (state_q == RST_MV);
  assign bus.move_start   = (state_q == ARM);
  assign bus.move_load    = (state_q == ISSUE);
  assign bus.move_input   = mv_in_q;
  assign bus.turn         = turn_q;
  assign bus.timeout_flag = to_flag_q;
  assign bus.round_over   = rnd_over_q;
  assign bus.round_winner = rnd_win_q;
  assign bus.p1_score     = p1_sc_q;
  assign bus.p2_score     = p2_sc_q;
  assign bus.match_over   = match_q;
endmodule

// File: doc/game_turn_controller.md
Name: game_turn_controller

Overview:
Sequences a `single_move` instance through complete two-player SubtractSquare matches. It does three jobs:
- Routes the active player's keypad input and load key into `single_move`, and enforces alternating turns.
- Applies a per-turn timeout that forces a move.
- Detects the end of each round (`game_state` == 0), keeps per-player round scores, and re-arms `single_move` for the next round until one player reaches `WIN_SCORE`.

Parameters:
- `CNT_W`, 28: width of the turn-timeout counter.
- `TURN_TIMEOUT`, 150000000: cycles allowed per turn before a forced move is issued (3 s at 50 MHz); legal range 2..2^CNT_W-1.
- `SETTLE_CYCLES`, 4: cycles waited after a load pulse before `game_state` is sampled; must be at least 3.
- `WIN_SCORE`, 3: rounds needed to win the match; legal range 1..15.

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  reset, asynchronous, active-high (asserted = 1), despite the name
- `start`  in  1  start/next-round key, level input, rising edge used
- `p1_load`  in  1  player 1 load key, level input, rising edge used
- `p2_load`  in  1  player 2 load key, level input, rising edge used
- `p1_input`  in  4  player 1 chosen root
- `p2_input`  in  4  player 2 chosen root
- `game_state`  in  8  `next_game_state` from `single_move`
- `move_reset`  out  1  drives `single_move` `reset_n` (active-high)
- `move_start`  out  1  drives `single_move` `start`
- `move_load`  out  1  drives `single_move` `load_input`
- `move_input`  out  4  drives `single_move` `player_input`
- `turn`  out  1  active player: 0 = P1, 1 = P2
- `timeout_flag`  out  1  one-cycle pulse when a forced move is issued
- `round_over`  out  1  high while a round has ended and no new round has started
- `round_winner`  out  1  winner of the last round; valid while `round_over` is high
- `p1_score`  out  4  player 1 rounds won
- `p2_score`  out  4  player 2 rounds won
- `match_over`  out  1  high once a score equals `WIN_SCORE`

Behaviour:
- Reset, asynchronous and active-high:
  - State goes to IDLE.
  - `move_reset` = 1; all other outputs = 0.
  - Edge-detect registers are cleared.
  - Reset asserted mid-operation aborts immediately; there is no partial score update.
- Edge detection: `start`, `p1_load` and `p2_load` are each registered once. An edge is `x & ~x_q`, so one press yields exactly one event.
- `move_reset` is 1 in IDLE and RST_MV only. `move_start` is 1 in ARM only. `move_load` is 1 in ISSUE only.
- `move_input` is held stable from ISSUE through the end of SETTLE.
- FSM states and transitions:
  - IDLE: on a `start` edge, clear both scores, set `turn` = 0, go to RST_MV.
  - RST_MV: one cycle, then ARM.
  - ARM: one cycle, then INIT_WAIT.
  - INIT_WAIT: wait `SETTLE_CYCLES`. If `game_state` == 0 (degenerate initial state), go back to RST_MV with no score change. Otherwise go to TURN_WAIT and clear the timer.
  - TURN_WAIT:
    - On the active player's load edge, latch that player's input into `move_input` and go to ISSUE.
    - Load edges from the inactive player are ignored. If both players press in the same cycle, only the active player's edge counts.
    - If the timer reaches `TURN_TIMEOUT`-1 first, latch `move_input` = 0, pulse `timeout_flag`, and go to ISSUE. Input 0 is always invalid in `single_move`, so it produces the forced move.
    - If a load edge and the timeout coincide, the load edge wins and `timeout_flag` stays 0.
  - ISSUE: one cycle (`move_load` = 1), then SETTLE.
  - SETTLE: count `SETTLE_CYCLES`, then CHECK.
  - CHECK: one cycle.
    - If `game_state` == 0, the current player took the last counters and wins the round: increment that player's score, set `round_winner` = `turn`, set `round_over`, go to ROUND_END.
    - Otherwise toggle `turn`, clear the timer, go to TURN_WAIT.
  - ROUND_END: if a score equals `WIN_SCORE`, set `match_over` and go to MATCH_END. Otherwise, on a `start` edge, clear `round_over`, set `turn` = loser of the last round, and go to RST_MV.
  - MATCH_END: hold all outputs. On a `start` edge, clear scores, `round_over` and `match_over`, and go to RST_MV.
- Scores saturate at `WIN_SCORE`, because a match ends there.
- The timer counts only in TURN_WAIT and never wraps.
- Latency:
  - A load edge in TURN_WAIT gives ISSUE on the next cycle; the registered key adds one more cycle before the edge is seen.
  - The new `game_state` is valid 3 cycles after ISSUE and is sampled `SETTLE_CYCLES`+1 cycles after ISSUE.

Decomposition:
- Package `ss_game_pkg`:
  - FSM state localparams: IDLE, RST_MV, ARM, INIT_WAIT, TURN_WAIT, ISSUE, SETTLE, CHECK, ROUND_END, MATCH_END.
  - `PLAYER_1` = 1'b0, `PLAYER_2` = 1'b1.
  - `FORCED_INPUT` = 4'd0.
- Sub-module `turn_timer`: `clk`/`reset_n`, `clear`, `enable`, terminal-count pulse output. It is reused by the SETTLE counter with a small count.

Test Plan:
- Reset behaviour: assert `reset_n` mid-SETTLE → all outputs 0 except `move_reset` = 1 within the same cycle; a `start` edge afterwards yields `move_reset` 1→0 and `move_start` high for one cycle.
- Valid move: bench model initial state 20, P1 presses with `p1_input` = 4 → `move_load` pulses once with `move_input` = 4; after SETTLE, state 4 ≠ 0 so `turn` = 1.
- Turn order: P2 presses repeatedly while `turn` = 0 → no `move_load`; simultaneous P1+P2 press → `move_input` = `p1_input`.
- Timeout: `TURN_TIMEOUT` = 10, no press → `timeout_flag` and `move_load` on the tenth TURN_WAIT cycle, `move_input` = 0.
- Round end: state 4, P2 enters 2 → `game_state` = 0, `round_winner` = 1, `p2_score` = 1, `round_over` = 1; next `start` edge → `turn` = 0 (P1 lost).
- Match: `WIN_SCORE` = 2, P1 wins two rounds → `p1_score` = 2 and `match_over` = 1 with no further moves; `start` edge → scores reset to 0.
